// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready flow control, flush-to-NOP, bubbles and a
// saturating stall counter. Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer.
module pipe_stage_reg #(
  parameter int              XLEN      = 32,
  parameter int              SIDE_W    = 8,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013,
  parameter int              CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [XLEN-1:0]   instr_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [SIDE_W-1:0] side_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   instr_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [SIDE_W-1:0] side_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              r_m_valid;
  logic [XLEN-1:0]   r_m_instr;
  logic [XLEN-1:0]   r_m_pc;
  logic [SIDE_W-1:0] r_m_side;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_ready;
  logic              w_up;
  logic              w_dn;
  logic              w_m_load;
  logic              w_m_bubble;
  logic [XLEN-1:0]   w_m_instr;
  logic [XLEN-1:0]   w_m_pc;
  logic [SIDE_W-1:0] w_m_side;

  assign w_up = valid_i && w_ready;
  assign w_dn = r_m_valid && ready_i;

`ifdef PIPE_STAGE_SKID_EN
  logic              r_s_valid;
  logic [XLEN-1:0]   r_s_instr;
  logic [XLEN-1:0]   r_s_pc;
  logic [SIDE_W-1:0] r_s_side;
  logic              w_s_load;
  logic              w_s_clr;

  // ready depends only on state (and flush), never on ready_i
  assign w_ready = flush_i || !r_s_valid;

  always_comb begin
    w_m_load   = 1'b0;
    w_m_bubble = 1'b0;
    w_m_instr  = instr_i;
    w_m_pc     = pc_i;
    w_m_side   = side_i;
    w_s_load   = 1'b0;
    w_s_clr    = 1'b0;
    if (r_s_valid) begin
      // S full blocks upstream; drain it into M first to keep order
      if (w_dn) begin
        w_m_load  = 1'b1;
        w_m_instr = r_s_instr;
        w_m_pc    = r_s_pc;
        w_m_side  = r_s_side;
        w_s_clr   = 1'b1;
      end
    end else if (w_up) begin
      if (!r_m_valid || ready_i) w_m_load = 1'b1;
      else                       w_s_load = 1'b1;
    end else if (w_dn) begin
      w_m_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s_valid <= 1'b0;
      r_s_instr <= NOP_INSTR;
      r_s_pc    <= '0;
      r_s_side  <= '0;
    end else if (flush_i || w_s_clr) begin
      r_s_valid <= 1'b0;
    end else if (w_s_load) begin
      r_s_valid <= 1'b1;
      r_s_instr <= instr_i;
      r_s_pc    <= pc_i;
      r_s_side  <= side_i;
    end
  end
`else
  assign w_ready = flush_i || !r_m_valid || ready_i;

  always_comb begin
    w_m_load   = 1'b0;
    w_m_bubble = 1'b0;
    w_m_instr  = instr_i;
    w_m_pc     = pc_i;
    w_m_side   = side_i;
    if (w_up)      w_m_load   = 1'b1;
    else if (w_dn) w_m_bubble = 1'b1;
  end
`endif

  // flush keeps pc/side so the killed slot still shows where it came from
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_m_valid <= 1'b0;
      r_m_instr <= NOP_INSTR;
      r_m_pc    <= '0;
      r_m_side  <= '0;
    end else if (flush_i || w_m_bubble) begin
      r_m_valid <= 1'b0;
      r_m_instr <= NOP_INSTR;
    end else if (w_m_load) begin
      r_m_valid <= 1'b1;
      r_m_instr <= w_m_instr;
      r_m_pc    <= w_m_pc;
      r_m_side  <= w_m_side;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_stall_cnt <= '0;
    else if (r_m_valid && !ready_i && !flush_i && r_stall_cnt != CNT_MAX)
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
  end

  assign ready_o     = w_ready;
  assign valid_o     = r_m_valid;
  assign instr_o     = r_m_instr;
  assign pc_o        = r_m_pc;
  assign side_o      = r_m_side;
  assign stall_cnt_o = r_stall_cnt;

endmodule
